// File: rtl/reg_pipe_pkg.sv
// Shared defaults and helpers for the reg_pipe_sclr pipeline register chain.
package reg_pipe_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 3;

    // Width needed to count 0..depth occupied stages.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned DefCntW = cnt_width(DefDepth);

    // One stage's contents at the default width.
    typedef struct packed {
        logic                valid;
        logic [DefWidth-1:0] data;
    } stage_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: valid bit plus data register with synchronous clear.
module pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_sclr,
    input  logic             i_adv,
    input  logic             i_src_valid,
    input  logic [WIDTH-1:0] i_src_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Load from the source when advancing; data only overwritten by a real item.
    always_ff @(posedge clk) begin
        if (i_rst || i_sclr) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_adv) begin
            r_valid <= i_src_valid;
            if (i_src_valid) begin
                r_data <= i_src_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/reg_pipe_sclr.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse, global enable
// and synchronous flush. Optional occupancy counter under REG_PIPE_SCLR_CNT_EN.
module reg_pipe_sclr
    import reg_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sclr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    logic             w_go;
    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_adv;
    logic [WIDTH-1:0] w_d [DEPTH];

    assign w_go = en & ~sclr & ~rst;

    // Ready chain: stage k advances when it or any stage downstream has a hole,
    // or the whole tail drains via out_ready. Unrolled so no net feeds itself.
    always_comb begin
        logic w_hole;
        w_hole = out_ready;
        w_adv  = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            w_hole   = w_hole | ~w_v[k];
            w_adv[k] = w_go & w_hole;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_data;

        if (k == 0) begin : g_head
            assign w_src_valid = in_valid;
            assign w_src_data  = in_data;
        end else begin : g_body
            assign w_src_valid = w_v[k-1];
            assign w_src_data  = w_d[k-1];
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk        (clk),
            .i_rst      (rst),
            .i_sclr     (sclr),
            .i_adv      (w_adv[k]),
            .i_src_valid(w_src_valid),
            .i_src_data (w_src_data),
            .o_valid    (w_v[k]),
            .o_data     (w_d[k])
        );
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_v[DEPTH-1] & en;
    assign out_data  = w_d[DEPTH-1];

`ifdef REG_PIPE_SCLR_CNT_EN
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CNT_W-1:0] r_count;

    assign w_in_xfer  = in_valid & in_ready;
    // out_valid is still driven during a flush/reset, but nothing leaves then.
    assign w_out_xfer = out_valid & out_ready & ~sclr & ~rst;

    // Occupancy tracks popcount of stage valid bits.
    always_ff @(posedge clk) begin
        if (rst || sclr) begin
            r_count <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_out_xfer && !w_in_xfer) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count = r_count;
`else
    assign count = '0;
`endif

endmodule

// File: doc/reg_pipe_sclr.md
Name: reg_pipe_sclr

Overview:
Parametrised pipeline register chain: DEPTH stages of WIDTH-bit data, each stage carrying a valid bit.
Uses a valid/ready handshake on both sides. Stages collapse bubbles, so an empty stage fills even while downstream is stalled.
Provides global enable and synchronous clear (flush).
Sits between datapath units that need fixed registered latency plus backpressure; replaces bare enable/clear register banks wherever flow control is needed.

Parameters:
WIDTH, 8, data bits per stage.
DEPTH, 3, number of register stages (>=1).
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived; do not override).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
en  in  1  global enable; 0 freezes all state.
sclr  in  1  synchronous flush; empties all stages.
in_valid  in  1  upstream has data.
in_data  in  WIDTH  upstream data.
in_ready  out  1  stage 0 can accept this cycle.
out_valid  out  1  last stage holds data.
out_data  out  WIDTH  last stage data.
out_ready  in  1  downstream accepts.
count  out  CNT_W  number of valid stages (see Optional Feature).

Behaviour:
- Priority: rst > sclr > en. rst and sclr are both synchronous.
- Reset: all stage valid bits = 0, all stage data = 0, count = 0. Hence out_valid = 0, out_data = 0.
- Stage k (0 = input side, DEPTH-1 = output side) holds v[k] and d[k].
- Stage k advance condition:
  - adv[DEPTH-1] = en & ~sclr & (~v[DEPTH-1] | out_ready).
  - adv[k] = en & ~sclr & (~v[k] | adv[k+1]). This is a combinational ready chain, no skid.
- in_ready = adv[0].
- out_valid = v[DEPTH-1] & en. out_data = d[DEPTH-1]; data is held stable while out_valid=1 and out_ready=0.
- When adv[k] = 1, stage k loads from stage k-1 (stage 0 loads from in_valid/in_data): v[k] <= source valid; d[k] <= source data only if source valid, otherwise d[k] holds.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency: DEPTH cycles from input transfer to out_valid with no backpressure. Throughput is 1/cycle when out_ready is held 1.
- Full: all v=1 and out_ready=0 -> in_ready=0, no state change.
- Full with out_ready=1: simultaneous input and output transfer in the same cycle; count unchanged.
- Bubble collapse: with out_ready=0 and v[0]=1, v[1]=0, the item moves to stage 1 next cycle and in_ready stays 1.
- en=0: in_ready=0, out_valid=0, nothing moves; state is retained exactly. Resumes seamlessly when en returns to 1.
- sclr=1: in_ready=0, out_valid is still driven but no output transfer completes. Next cycle all v=0, d=0, count=0.
- rst asserted mid-stream: same result as sclr; any in-flight items are lost.
- DEPTH=1 must work: a single stage with ready = ~v | out_ready.

Optional Feature:
- Macro: REG_PIPE_SCLR_CNT_EN.
- Defined: count register tracks occupancy.
  - +1 on input transfer only; -1 on output transfer only; unchanged when both or neither occur.
  - Cleared on rst and sclr.
  - Invariant: count equals popcount(v) at all times.
- Undefined: count tied to 0; no counter logic is synthesised. The port remains so instantiations stay uniform.

Decomposition:
- Package reg_pipe_pkg holds:
  - the default WIDTH/DEPTH localparams;
  - a clog2-based helper constant for CNT_W;
  - a stage_t struct {valid, data} parametrised through localparam width.
- Sub-module pipe_stage: one stage with valid + data register.
  - Inputs: adv, src_valid, src_data, sclr, rst.
  - Instantiated in a generate loop over DEPTH; the ready chain is computed in the parent.

Test Plan:
- Reset / latency: rst 2 cycles, then in_data=0xA5 for 1 cycle with out_ready=1 -> out_valid=1 with out_data=0xA5 exactly 3 cycles later. All outputs are 0 during and after reset until then.
- Streaming: 10 back-to-back items 0x00..0x09 with out_ready=1 -> output in order, one per cycle, no gaps after the initial 3-cycle latency, count steady at 3.
- Backpressure / full: out_ready=0, push 0x11, 0x22, 0x33 -> in_ready=0 after the 3rd transfer, out_data=0x11 held. Raise out_ready -> 0x11, 0x22, 0x33 drain in order. A 4th item pushed in the same cycle is accepted.
- Bubble collapse: out_ready=0, push 0x44, idle 1 cycle, push 0x55 -> both held in stages 2,1 and in_ready remains 1 until the 3rd item arrives.
- Flush: 3 items in flight, pulse sclr together with in_valid=1 -> in_ready=0 that cycle, next cycle out_valid=0 and count=0, and no item is ever emitted.
- Enable freeze: mid-stream, en=0 for 4 cycles -> in_ready=0, out_valid=0, internal contents unchanged. After en=1, the sequence continues with no loss or duplication.
